// File: rtl/parity_engine.sv
// Serial ones counter: consumes STEP bits of a DATA_W-bit word per clock and
// reports the ones count, even/odd flags, a generated parity bit and a parity check.
module parity_engine #(
    parameter int DATA_W = 16,
    parameter int STEP   = 1
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        start,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        odd_mode,
    input  logic                        check_en,
    input  logic                        parity_in,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(DATA_W+1)-1:0] ones_count,
    output logic                        even_parity,
    output logic                        odd_parity,
    output logic                        parity_bit,
    output logic                        parity_err
);
    localparam int BEATS = DATA_W / STEP;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PC_W  = $clog2(STEP + 1);
    localparam int BC_W  = $clog2(BEATS + 1);

    if (DATA_W < 2) begin : g_bad_width
        $error("parity_engine: DATA_W must be at least 2");
    end
    if ((STEP < 1) || ((DATA_W % STEP) != 0)) begin : g_bad_step
        $error("parity_engine: STEP must divide DATA_W exactly");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DATA_W-1:0]   shift_r;
    logic [CNT_W-1:0]    acc_r;
    logic [BC_W-1:0]     beat_cnt_r;
    logic [BC_W-1:0]     beat_nxt_s;
    logic                odd_mode_r;
    logic                check_en_r;
    logic                parity_in_r;
    logic                new_pbit_s;

    function automatic logic [PC_W-1:0] popcount(input logic [STEP-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < STEP; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a word leaves SHIFT once its last beat has been consumed
    always_comb begin
        state_s    = state_r;
        beat_nxt_s = beat_cnt_r + BC_W'(1);
        new_pbit_s = acc_r[0] ^ odd_mode_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (beat_nxt_s == BC_W'(BEATS)) begin
                    state_s = FINISH;
                end else begin
                    state_s = SHIFT;
                end
            end
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shift_r     <= '0;
            acc_r       <= '0;
            beat_cnt_r  <= '0;
            odd_mode_r  <= 1'b0;
            check_en_r  <= 1'b0;
            parity_in_r <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ones_count  <= '0;
            even_parity <= 1'b0;
            odd_parity  <= 1'b0;
            parity_bit  <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r     <= data_in;
                        odd_mode_r  <= odd_mode;
                        check_en_r  <= check_en;
                        parity_in_r <= parity_in;
                        acc_r       <= '0;
                        beat_cnt_r  <= '0;
                        busy        <= 1'b1;
                        even_parity <= 1'b0;
                        odd_parity  <= 1'b0;
                        parity_err  <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc_r      <= acc_r + CNT_W'(popcount(shift_r[STEP-1:0]));
                    shift_r    <= shift_r >> STEP;
                    beat_cnt_r <= beat_nxt_s;
                end
                FINISH: begin
                    ones_count  <= acc_r;
                    even_parity <= ~acc_r[0];
                    odd_parity  <= acc_r[0];
                    parity_bit  <= new_pbit_s;
                    parity_err  <= check_en_r & (parity_in_r != new_pbit_s);
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/parity_engine.md
# parity_engine

Parametrised successor to the fixed 8-bit parity checker. Serially counts the ones in a DATA_W-bit word, STEP bits per clock. Produces:
- even/odd flags, a generated parity bit for even or odd schemes, and the ones count;
- optionally, a comparison against a supplied parity bit, giving an error flag.

It sits behind the user-project IO wrapper, with the same start/busy handshake as the existing checker and an added done pulse.

## Interface

Parameters:
- DATA_W, 16, input word width; ≥2.
- STEP, 1, bits consumed per SHIFT cycle; must divide DATA_W exactly (illegal values are an elaboration error).
- Derived, not overridable: BEATS = DATA_W/STEP; CNT_W = $clog2(DATA_W+1).

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when state = IDLE.
- data_in  in  DATA_W  word; sampled on the accepting edge.
- odd_mode  in  1  0 = even scheme, 1 = odd scheme; sampled with start.
- check_en  in  1  enables comparison; sampled with start.
- parity_in  in  1  expected parity bit; sampled with start.
- busy  out  1  high from the accept edge until the result edge.
- done  out  1  one-cycle pulse when results update.
- ones_count  out  CNT_W  number of ones in the word.
- even_parity  out  1  ones_count is even.
- odd_parity  out  1  ones_count is odd.
- parity_bit  out  1  bit that makes total ones even (odd_mode=0) or odd (odd_mode=1).
- parity_err  out  1  check_en & (parity_in != parity_bit).

## Operation

- FSM states: IDLE, SHIFT, FINISH.

IDLE
- On start: load shift register ← data_in; capture odd_mode, check_en, parity_in; clear accumulator and beat counter.
- On the same edge: busy←1, even_parity←0, odd_parity←0, parity_err←0; go to SHIFT.
- Without start: hold all registers and outputs.

SHIFT
- Each cycle: accumulator += popcount(shift_reg[STEP-1:0]); shift_reg >>= STEP (zero fill); beat counter += 1.
- After the BEATS-th beat, go to FINISH.

FINISH
- Register the outputs:
  - ones_count ← accumulator;
  - even_parity ← ~acc[0]; odd_parity ← acc[0];
  - parity_bit ← acc[0] ^ captured odd_mode;
  - parity_err ← captured check_en & (captured parity_in != new parity_bit).
- Set done←1 and busy←0; go to IDLE.

General rules
- done deasserts on the following edge.
- Results are held stable until the next accepted start.
- start while busy (SHIFT or FINISH) is ignored and not queued.
- data_in, odd_mode, check_en and parity_in are don't-care except on the accepting edge.
- Arithmetic:
  - The accumulator is CNT_W bits and cannot overflow (maximum DATA_W).
  - The per-beat popcount is $clog2(STEP+1) bits, zero-extended to CNT_W.
  - The beat counter is $clog2(BEATS+1) bits.

## Timing

- Reset (on any edge with wb_rst_i=1, in any state, including mid-SHIFT):
  - state→IDLE; the in-flight operation is discarded with no done pulse.
  - Outputs all 0: busy, done, ones_count, even_parity, odd_parity, parity_bit, parity_err.
  - Shift register, accumulator and beat counter are cleared.
- Reset has priority over start on the same edge.
- Latency, with start accepted at edge E0:
  - SHIFT beats occur at edges E0+1 … E0+BEATS.
  - FINISH at edge E0+BEATS+1: results valid, done=1, busy=0.
  - Defaults (16/1): results 17 cycles after accept.
- Back-to-back: start held high during the done cycle is accepted at E0+BEATS+2, so throughput is one word per BEATS+2 cycles.
- busy is registered, never combinational from start.

## Test plan

1. After reset (DATA_W=16, STEP=1): all outputs are 0. Pulse start with data_in=0x0000, odd_mode=0 → busy=1 for edges 1..17 after accept; at edge 17: done=1 for one cycle, ones_count=0, even_parity=1, odd_parity=0, parity_bit=0.
2. data_in=0x8001, odd_mode=1, check_en=1, parity_in=0 → ones_count=2, even_parity=1, parity_bit=1, parity_err=1. Repeat with parity_in=1 → parity_err=0.
3. STEP=4 instance: data_in=0xFFFF → done at edge 5 after accept, ones_count=16, even_parity=1. data_in=0x0007 → ones_count=3, odd_parity=1, parity_bit=1 (odd_mode=0).
4. Start re-pulsed with a different word at accept+3 and accept+17 (the FINISH edge) → both ignored; results match the first word. Start held through the done cycle → second word accepted at accept+18, done again at accept+35.
5. Assert wb_rst_i at accept+5 mid-SHIFT → busy=0 next edge, no done pulse, all outputs 0. A fresh start after reset with 0x00FF → ones_count=8 at normal latency.
6. check_en=0 with any parity_in mismatch (data 0x0001, parity_in=0) → parity_err=0, parity_bit=1. Word changes on data_in during SHIFT do not affect ones_count.
